exc_ctrl: RTL

- Exception/interrupt sequencer for the 5-stage MIPS pipeline.
- Samples the MEM-stage exception summary and CP0 Status/Cause/EPC, and resolves a single winning event by priority.
- Issues the CP0 update strobes (EPC, Cause.ExcCode/BD, Status.EXL set/clear) and holds a pipeline flush with a redirect PC for a fixed number of cycles.
- Also executes ERET by redirecting to EPC and clearing EXL.

---
 rtl/exc_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the MEM stage: resolves one winning
// event, issues CP0 strobes, holds flush and redirect for FLUSH_CYCLES.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_*             MEM-stage instruction info and exception flags
//   status_i/cause_i/epc_i  current CP0 registers
//   timer_int         CP0 timer interrupt (ORed into IP7)
//   flush, busy       held for FLUSH_CYCLES cycles after an event
//   pc_load, new_pc   one-cycle PC redirect (new_pc held during flush)
//   epc_we/epc_wdata, cause_we/exccode/bd, exl_set/exl_clr  CP0 strobes
module exc_ctrl #(
  parameter int             DW           = 32,
  parameter logic [DW-1:0]  EXC_VECTOR   = 32'h00000020,
  parameter int             FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_pc,
  input  logic          mem_in_delayslot,
  input  logic [5:0]    mem_exc,
  input  logic          mem_is_store,
  input  logic          mem_eret,
  input  logic [DW-1:0] status_i,
  input  logic [DW-1:0] cause_i,
  input  logic [DW-1:0] epc_i,
  input  logic          timer_int,
  output logic          flush,
  output logic          pc_load,
  output logic [DW-1:0] new_pc,
  output logic          epc_we,
  output logic [DW-1:0] epc_wdata,
  output logic          cause_we,
  output logic [4:0]    exccode,
  output logic          bd,
  output logic          exl_set,
  output logic          exl_clr,
  output logic          busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  logic [0:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_flush;
  logic          r_pc_load;
  logic [DW-1:0] r_new_pc;
  logic          r_epc_we;
  logic [DW-1:0] r_epc_wdata;
  logic          r_cause_we;
  logic [4:0]    r_exccode;
  logic          r_bd;
  logic          r_exl_set;
  logic          r_exl_clr;

  logic [7:0]    w_ip;
  logic          w_int;
  logic          w_exc_any;
  logic [4:0]    w_code;
  logic          w_take_exc;
  logic          w_take_eret;
  logic [DW-1:0] w_epc;
  logic          w_unused;

  assign w_ip      = cause_i[15:8] | {timer_int, 7'b0};
  assign w_int     = status_i[0] & ~status_i[1]
                   & (|(status_i[15:8] & w_ip));
  assign w_exc_any = w_int | (|mem_exc);

  always_comb begin
    w_code = 5'h00;
    priority case (1'b1)
      w_int:      w_code = 5'h00;
      mem_exc[0]: w_code = 5'h04;
      mem_exc[1]: w_code = 5'h0A;
      mem_exc[2]: w_code = 5'h0C;
      mem_exc[3]: w_code = 5'h0D;
      mem_exc[4]: w_code = 5'h08;
      mem_exc[5]: w_code = mem_is_store ? 5'h05 : 5'h04;
      default:    w_code = 5'h00;
    endcase
  end

  // An exception always beats a simultaneous ERET.
  assign w_take_exc  = mem_valid & w_exc_any;
  assign w_take_eret = mem_valid & mem_eret & ~w_exc_any;

  // Delay-slot faults restart at the branch, one word back (mod 2^DW).
  assign w_epc = mem_in_delayslot ? (mem_pc - DW'(4)) : mem_pc;

  assign w_unused = ^{status_i[DW-1:16], status_i[7:2],
                      cause_i[DW-1:16], cause_i[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_flush     <= 1'b0;
      r_pc_load   <= 1'b0;
      r_new_pc    <= '0;
      r_epc_we    <= 1'b0;
      r_epc_wdata <= '0;
      r_cause_we  <= 1'b0;
      r_exccode   <= 5'd0;
      r_bd        <= 1'b0;
      r_exl_set   <= 1'b0;
      r_exl_clr   <= 1'b0;
    end else begin
      r_pc_load  <= 1'b0;
      r_epc_we   <= 1'b0;
      r_cause_we <= 1'b0;
      r_exl_set  <= 1'b0;
      r_exl_clr  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_take_exc) begin
            r_state     <= S_FLUSH;
            r_cnt       <= CNT_INIT;
            r_flush     <= 1'b1;
            r_pc_load   <= 1'b1;
            r_new_pc    <= EXC_VECTOR;
            r_epc_we    <= ~status_i[1];
            r_epc_wdata <= w_epc;
            r_cause_we  <= 1'b1;
            r_exccode   <= w_code;
            r_bd        <= mem_in_delayslot;
            r_exl_set   <= 1'b1;
          end else if (w_take_eret) begin
            r_state     <= S_FLUSH;
            r_cnt       <= CNT_INIT;
            r_flush     <= 1'b1;
            r_pc_load   <= 1'b1;
            r_new_pc    <= epc_i;
            r_epc_wdata <= '0;
            r_exccode   <= 5'd0;
            r_bd        <= 1'b0;
            r_exl_clr   <= 1'b1;
          end else begin
            r_flush     <= 1'b0;
            r_new_pc    <= '0;
            r_epc_wdata <= '0;
            r_exccode   <= 5'd0;
            r_bd        <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_IDLE;
            r_flush     <= 1'b0;
            r_new_pc    <= '0;
            r_epc_wdata <= '0;
            r_exccode   <= 5'd0;
            r_bd        <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign flush     = r_flush;
  assign busy      = (r_state == S_FLUSH);
  assign pc_load   = r_pc_load;
  assign new_pc    = r_new_pc;
  assign epc_we    = r_epc_we;
  assign epc_wdata = r_epc_wdata;
  assign cause_we  = r_cause_we;
  assign exccode   = r_exccode;
  assign bd        = r_bd;
  assign exl_set   = r_exl_set;
  assign exl_clr   = r_exl_clr;

endmodule
